// File: rtl/onchip_mem_arb_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

   localparam int ADDR_W    = 13;
   localparam int DATA_W    = 16;
   localparam int BE_W      = DATA_W / 8;
   localparam int NUM_WORDS = 8000;

   // Identifies which master issued an access.
   typedef logic mid_t;

   localparam mid_t MID_M0 = 1'b0;
   localparam mid_t MID_M1 = 1'b1;

endpackage

// File: rtl/onchip_mem_arbiter_rr.sv
// Two-way round-robin arbiter.
// Grant is combinational from the requests and the last winner.
// Grant is forced to zero while reset is high.
module rr_arbiter2
   import onchip_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   mid_t r_last_grant;

   // Pick the winner: a lone requester wins; on a tie the master that did not win last time wins.
   always_comb begin
      grant = 2'b00;
      if (!reset) begin
         if (req[0] && (!req[1] || (r_last_grant == MID_M1))) begin
            grant = 2'b01;
         end else if (req[1]) begin
            grant = 2'b10;
         end
      end
   end

   // Remember the last winner; hold the pointer through idle cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= MID_M1;
      end else if (|grant) begin
         r_last_grant <= mid_t'(grant[1]);
      end
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port 1-cycle-latency RAM between two Avalon-MM masters.
// At most one access is issued per clock.
// Out-of-range accesses never reach the RAM; out-of-range reads return zero.
module onchip_mem_arbiter
   import onchip_mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic              mem_debugaccess,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   output logic              mem_reset_req,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic [1:0]        w_rd;
   logic [1:0]        w_wr;
   logic [1:0]        w_req;
   logic [1:0]        w_grant;
   logic [1:0]        w_rdv;
   logic [1:0]        w_wait;
   logic [ADDR_W-1:0] w_addr  [2];
   logic [BE_W-1:0]   w_be    [2];
   logic [DATA_W-1:0] w_wdata [2];

   mid_t              w_sel;
   logic              w_any;
   logic              w_sel_wr;
   logic              w_oor;
   logic              w_rd_accept;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_rsp_data;

   logic              r_rsp_valid;
   mid_t              r_rsp_id;
   logic              r_rsp_oor;

   // Gather both master ports into indexable arrays.
   assign w_rd       = {m1_read,  m0_read};
   assign w_wr       = {m1_write, m0_write};
   assign w_addr[0]  = m0_address;
   assign w_addr[1]  = m1_address;
   assign w_be[0]    = m0_byteenable;
   assign w_be[1]    = m1_byteenable;
   assign w_wdata[0] = m0_writedata;
   assign w_wdata[1] = m1_writedata;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (w_req),
      .grant (w_grant)
   );

   // Winner selection and range decode. A read with write asserted is a write.
   assign w_sel       = mid_t'(w_grant[1]);
   assign w_any       = |w_grant;
   assign w_sel_wr    = w_wr[w_sel];
   assign w_sel_addr  = w_addr[w_sel];
   assign w_oor       = (w_sel_addr >= ADDR_W'(NUM_WORDS));
   assign w_rd_accept = w_any & ~w_sel_wr;

   // RAM side: out-of-range accesses are accepted but never select the RAM.
   assign mem_address     = w_sel_addr;
   assign mem_chipselect  = w_any & ~w_oor;
   assign mem_write       = mem_chipselect & w_sel_wr;
   assign mem_debugaccess = mem_write;
   assign mem_byteenable  = w_sel_wr ? w_be[w_sel] : {BE_W{1'b1}};
   assign mem_writedata   = w_wdata[w_sel];
   assign mem_clken       = 1'b1;
   assign mem_reset_req   = 1'b0;

   // Track the owner of the read issued last cycle so its data can be steered back.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= MID_M0;
         r_rsp_oor   <= 1'b0;
      end else begin
         r_rsp_valid <= w_rd_accept;
         r_rsp_id    <= w_sel;
         r_rsp_oor   <= w_oor;
      end
   end

   // Shared read data bus; only the valid strobe is per-master.
   assign w_rsp_data = r_rsp_oor ? '0 : mem_readdata;

   // Per-master handshake: waitrequest while reset or losing, valid steered by id.
   // Valid is masked by reset so a read accepted just before reset rises gets no response.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_master
         assign w_req[gi]  = w_rd[gi] | w_wr[gi];
         assign w_wait[gi] = reset | (w_req[gi] & ~w_grant[gi]);
         assign w_rdv[gi]  = r_rsp_valid & ~reset & (r_rsp_id == mid_t'(gi));
      end
   endgenerate

   assign m0_waitrequest   = w_wait[0];
   assign m1_waitrequest   = w_wait[1];
   assign m0_readdatavalid = w_rdv[0];
   assign m1_readdatavalid = w_rdv[1];
   assign m0_readdata      = w_rsp_data;
   assign m1_readdata      = w_rsp_data;

endmodule
